// File: rtl/vga_timing_monitor.sv
// Receive-side VGA raster checker: measures line/frame geometry on pixel
// ticks, locks to the expected mode, counts lit active pixels per frame and
// records sticky timing errors.
//
// state  | meaning
// SEARCH | no raster reference yet; waiting for the first vsync leading edge
// ALIGN  | frame boundary known; waiting for one fully passing frame
// LOCKED | raster matches the expected mode; failing frames raise err bits
module vga_timing_monitor #(
  parameter int H_TOTAL_EXP     = 800,
  parameter int H_ACTIVE_EXP    = 640,
  parameter int V_TOTAL_EXP     = 525,
  parameter int V_ACTIVE_EXP    = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] h_total,
  output logic [10:0] h_sync_w,
  output logic [10:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_w,
  output logic [10:0] v_active,
  output logic [19:0] lit_count,
  output logic [4:0]  err
);

  localparam logic [10:0] H_TOT    = 11'(H_TOTAL_EXP);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE_EXP);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL_EXP);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE_EXP);
  localparam logic [10:0] H_TMO_M1 = 11'(2 * H_TOTAL_EXP - 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_e;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v, input logic en);
    if (en && (v != 11'h7FF)) return v + 11'd1;
    return v;
  endfunction

  function automatic logic [19:0] sat_inc20(input logic [19:0] v, input logic en);
    if (en && (v != 20'hF_FFFF)) return v + 20'd1;
    return v;
  endfunction

  logic        hs_a, vs_a, h_lead, h_trail, v_lead, v_trail, act_tick, lit_tick;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [10:0] h_run_q, h_run_d, hs_cnt_q, hs_cnt_d, line_cnt_q, line_cnt_d;
  logic        line_act_q, line_act_d;
  logic [10:0] v_cnt_q, v_cnt_d, vs_cnt_q, vs_cnt_d, v_act_q, v_act_d;
  logic [19:0] lit_q, lit_d;
  logic        bad_h_q, bad_h_d, bad_ha_q, bad_ha_d;
  logic [10:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d, h_active_q, h_active_d;
  logic [10:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d, v_active_q, v_active_d;
  logic [19:0] lit_count_q, lit_count_d;
  state_e      state_q, state_d;
  logic [4:0]  err_q, err_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  fail_bits;
  logic        timeout;

  assign hs_a     = SYNC_ACTIVE_LOW ? ~hsync : hsync;
  assign vs_a     = SYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign h_lead   = hs_a & ~hs_prev_q;
  assign h_trail  = ~hs_a & hs_prev_q;
  assign v_lead   = vs_a & ~vs_prev_q;
  assign v_trail  = ~vs_a & vs_prev_q;
  assign act_tick = ~hblank & ~vblank;
  assign lit_tick = act_tick & (|{vga_r, vga_g, vga_b});

  // Frame verdict from the accumulators as they stand before the edge tick;
  // the edge tick itself belongs to the new frame.
  assign fail_bits = {v_act_q != V_ACT, bad_ha_q, v_cnt_q != V_TOT, bad_h_q};
  assign timeout   = clk_en & ~h_lead & (h_run_q == H_TMO_M1);

  // Measurement datapath: counters advance and latch only on pixel ticks.
  always_comb begin
    hs_prev_d   = hs_prev_q;
    vs_prev_d   = vs_prev_q;
    h_run_d     = h_run_q;
    hs_cnt_d    = hs_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_act_d  = line_act_q;
    v_cnt_d     = v_cnt_q;
    vs_cnt_d    = vs_cnt_q;
    v_act_d     = v_act_q;
    lit_d       = lit_q;
    bad_h_d     = bad_h_q;
    bad_ha_d    = bad_ha_q;
    h_total_d   = h_total_q;
    h_sync_w_d  = h_sync_w_q;
    h_active_d  = h_active_q;
    v_total_d   = v_total_q;
    v_sync_w_d  = v_sync_w_q;
    v_active_d  = v_active_q;
    lit_count_d = lit_count_q;
    if (clk_en) begin
      hs_prev_d = hs_a;
      vs_prev_d = vs_a;
      if (h_lead) begin
        h_run_d    = 11'd1;
        h_total_d  = h_run_q;
        line_cnt_d = {10'd0, act_tick};
        line_act_d = act_tick;
        if (line_act_q) h_active_d = line_cnt_q;
      end else begin
        h_run_d    = sat_inc11(h_run_q, 1'b1);
        line_cnt_d = sat_inc11(line_cnt_q, act_tick);
        line_act_d = line_act_q | act_tick;
      end
      if (hs_a) hs_cnt_d = h_lead ? 11'd1 : sat_inc11(hs_cnt_q, 1'b1);
      if (h_trail) h_sync_w_d = hs_cnt_q;
      if (vs_a) vs_cnt_d = v_lead ? {10'd0, h_lead} : sat_inc11(vs_cnt_q, h_lead);
      if (v_trail) v_sync_w_d = vs_cnt_q;
      if (v_lead) begin
        v_total_d   = v_cnt_q;
        v_active_d  = v_act_q;
        lit_count_d = lit_q;
      end
      v_cnt_d  = sat_inc11(v_lead ? 11'd0 : v_cnt_q, h_lead);
      v_act_d  = sat_inc11(v_lead ? 11'd0 : v_act_q, h_lead & line_act_q);
      lit_d    = sat_inc20(v_lead ? 20'd0 : lit_q, lit_tick);
      bad_h_d  = (~v_lead & bad_h_q) | (h_lead & (h_run_q != H_TOT));
      bad_ha_d = (~v_lead & bad_ha_q) | (h_lead & line_act_q & (line_cnt_q != H_ACT));
    end
  end

  // Measurement registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      h_run_q     <= '0;
      hs_cnt_q    <= '0;
      line_cnt_q  <= '0;
      line_act_q  <= 1'b0;
      v_cnt_q     <= '0;
      vs_cnt_q    <= '0;
      v_act_q     <= '0;
      lit_q       <= '0;
      bad_h_q     <= 1'b0;
      bad_ha_q    <= 1'b0;
      h_total_q   <= '0;
      h_sync_w_q  <= '0;
      h_active_q  <= '0;
      v_total_q   <= '0;
      v_sync_w_q  <= '0;
      v_active_q  <= '0;
      lit_count_q <= '0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      h_run_q     <= h_run_d;
      hs_cnt_q    <= hs_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_act_q  <= line_act_d;
      v_cnt_q     <= v_cnt_d;
      vs_cnt_q    <= vs_cnt_d;
      v_act_q     <= v_act_d;
      lit_q       <= lit_d;
      bad_h_q     <= bad_h_d;
      bad_ha_q    <= bad_ha_d;
      h_total_q   <= h_total_d;
      h_sync_w_q  <= h_sync_w_d;
      h_active_q  <= h_active_d;
      v_total_q   <= v_total_d;
      v_sync_w_q  <= v_sync_w_d;
      v_active_q  <= v_active_d;
      lit_count_q <= lit_count_d;
    end
  end

  // Lock FSM next state, sticky errors and frame_done pulse; a timeout
  // overrides any frame edge on the same tick, and a set beats err_clr.
  always_comb begin
    state_d      = state_q;
    err_d        = (clk_en & err_clr) ? 5'd0 : err_q;
    frame_done_d = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      if (state_q != SEARCH) err_d[4] = 1'b1;
    end else if (clk_en && v_lead) begin
      case (state_q)
        SEARCH: state_d = ALIGN;
        ALIGN: begin
          frame_done_d = 1'b1;
          if (fail_bits == 4'd0) state_d = LOCKED;
        end
        LOCKED: begin
          frame_done_d = 1'b1;
          if (fail_bits != 4'd0) begin
            err_d[3:0] = err_d[3:0] | fail_bits;
            state_d    = ALIGN;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      err_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign frame_done = frame_done_q;
  assign h_total    = h_total_q;
  assign h_sync_w   = h_sync_w_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_sync_w   = v_sync_w_q;
  assign v_active   = v_active_q;
  assign lit_count  = lit_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a reduced 40x30 (32x24 active) raster.
module tb_vga_timing_monitor;
  localparam int HT  = 40;
  localparam int HA  = 32;
  localparam int VT  = 30;
  localparam int VA  = 24;
  localparam int LIT = 192;  // solid 8x16 glyph (128) + checkerboard 8x16 glyph (64)

  logic clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1, hblank = 1'b1, vblank = 1'b1, err_clr = 1'b0;
  logic [3:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic locked, frame_done;
  logic [10:0] h_total, h_sync_w, h_active, v_total, v_sync_w, v_active;
  logic [19:0] lit_count;
  logic [4:0] err;

  vga_timing_monitor #(
    .H_TOTAL_EXP(HT), .H_ACTIVE_EXP(HA), .V_TOTAL_EXP(VT), .V_ACTIVE_EXP(VA),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .err_clr(err_clr),
    .locked(locked), .frame_done(frame_done),
    .h_total(h_total), .h_sync_w(h_sync_w), .h_active(h_active),
    .v_total(v_total), .v_sync_w(v_sync_w), .v_active(v_active),
    .lit_count(lit_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h_total, h_sync_w, h_active, v_total, v_sync_w, v_active;
    logic [19:0] lit;
    logic        locked;
    logic [4:0]  err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;
  int hx = 0, vy = 0, div = 4;
  bit glyph_on = 0, short_line_pend = 0, short_frame = 0, clr_at_vlead = 0, clr_now = 0, kill_hs = 0;

  function automatic exp_t mk(input int vt, input int lit, input logic lk, input logic [4:0] e);
    exp_t r;
    r.h_total = 11'(HT); r.h_sync_w = 11'd4; r.h_active = 11'(HA);
    r.v_total = 11'(vt); r.v_sync_w = 11'd2; r.v_active = 11'(VA);
    r.lit = 20'(lit); r.locked = lk; r.err = e;
    return r;
  endfunction

  // One pixel tick at the current raster position, then idle cycles with junk inputs.
  task automatic drive_tick();
    bit hb, vb;
    @(negedge clk);
    hb = (hx >= HA);
    vb = (vy >= VA);
    hsync  = kill_hs ? 1'b1 : !(hx >= 34 && hx < 38);
    vsync  = !(vy >= 26 && vy < 28);
    hblank = hb;
    vblank = vb;
    vga_r = '0; vga_g = '0; vga_b = '0;
    if (hb || vb) vga_r = 4'hF;
    else if (glyph_on) begin
      if (hx >= 2 && hx < 10 && vy >= 2 && vy < 18) begin
        vga_r = 4'h8; vga_g = 4'h8; vga_b = 4'h8;
      end else if (hx >= 20 && hx < 28 && vy >= 4 && vy < 20 && ((hx + vy) % 2 == 0))
        vga_b = 4'h1;
    end
    err_clr = clr_now || (clr_at_vlead && hx == 0 && vy == 26);
    clk_en = 1'b1;
    for (int i = 1; i < div; i++) begin
      @(negedge clk);
      clk_en = 1'b0; err_clr = 1'b0;
      hsync = 1'($urandom); vsync = 1'($urandom);
      hblank = 1'($urandom); vblank = 1'($urandom);
      vga_g = 4'($urandom);
    end
    hx++;
    if (short_line_pend && hx == 38) begin hx = 39; short_line_pend = 0; end
    if (hx == HT) begin
      hx = 0; vy++;
      if (short_frame && vy == 28) begin vy = 29; short_frame = 0; end
      if (vy == VT) vy = 0;
    end
  endtask

  task automatic run_to_vlead(input bit expect_done, input exp_t e);
    int n = 0;
    while (!(hx == 0 && vy == 26) && n < 2 * HT * VT) begin drive_tick(); n++; end
    if (expect_done) sb_q.push_back(e);
    drive_tick();
    #1;
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL frame_done_missing: pending %0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick();
    #1;
  endtask

  // Scoreboard consumer: every frame_done pops one expected frame result.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame_done at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        if ({h_total, h_sync_w, h_active} !== {mon_e.h_total, mon_e.h_sync_w, mon_e.h_active}) begin
          miscompares++;
          $display("FAIL h_meas: got %0d/%0d/%0d expected %0d/%0d/%0d", h_total, h_sync_w, h_active,
                   mon_e.h_total, mon_e.h_sync_w, mon_e.h_active);
        end
        vectors++;
        if ({v_total, v_sync_w, v_active} !== {mon_e.v_total, mon_e.v_sync_w, mon_e.v_active}) begin
          miscompares++;
          $display("FAIL v_meas: got %0d/%0d/%0d expected %0d/%0d/%0d", v_total, v_sync_w, v_active,
                   mon_e.v_total, mon_e.v_sync_w, mon_e.v_active);
        end
        vectors++;
        if (lit_count !== mon_e.lit) begin
          miscompares++;
          $display("FAIL lit_count: got %0d expected %0d", lit_count, mon_e.lit);
        end
        vectors++;
        if ({locked, err} !== {mon_e.locked, mon_e.err}) begin
          miscompares++;
          $display("FAIL lock_err: got locked=%0b err=%b expected locked=%0b err=%b", locked, err,
                   mon_e.locked, mon_e.err);
        end
      end
    end
  end

  task automatic test_reset();
    #12;
    vectors++;
    if ({locked, frame_done, err} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 0", {locked, frame_done, err});
    end
    vectors++;
    if ({h_total, h_sync_w, h_active, v_total, v_sync_w, v_active, lit_count} !== 86'd0) begin
      miscompares++;
      $display("FAIL reset_meas: got %0h expected 0",
               {h_total, h_sync_w, h_active, v_total, v_sync_w, v_active, lit_count});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_nominal_lock();
    div = 4;
    run_to_vlead(0, mk(VT, 0, 0, 0));
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_after_first_edge: got %0b expected 0", locked);
    end
    run_to_vlead(1, mk(VT, 0, 1, 0));
  endtask

  task automatic test_glyphs();
    div = 2;
    glyph_on = 1;
    run_to_vlead(1, mk(VT, LIT, 1, 0));
    run_to_vlead(1, mk(VT, LIT, 1, 0));
  endtask

  task automatic test_short_line();
    short_line_pend = 1;
    run_to_vlead(1, mk(VT, LIT, 0, 5'b00001));
    run_to_vlead(1, mk(VT, LIT, 1, 5'b00001));
    run_to_vlead(1, mk(VT, LIT, 1, 5'b00001));
  endtask

  task automatic test_err_clr();
    short_frame = 1;
    clr_at_vlead = 1;
    run_to_vlead(1, mk(VT - 1, LIT, 0, 5'b00010));
    clr_at_vlead = 0;
    clr_now = 1;
    drive_tick();
    clr_now = 0;
    #1;
    vectors++;
    if (err !== 5'd0) begin
      miscompares++;
      $display("FAIL err_clr_alone: got %b expected 00000", err);
    end
    run_to_vlead(1, mk(VT, LIT, 1, 0));
  endtask

  task automatic test_timeout();
    kill_hs = 1;
    run_ticks(70);
    vectors++;
    if ({locked, err} !== 6'b1_00000) begin
      miscompares++;
      $display("FAIL pre_timeout: got locked=%0b err=%b expected locked=1 err=00000", locked, err);
    end
    run_ticks(10);
    vectors++;
    if ({locked, err} !== 6'b0_10000) begin
      miscompares++;
      $display("FAIL timeout: got locked=%0b err=%b expected locked=0 err=10000", locked, err);
    end
    kill_hs = 0;
    run_to_vlead(0, mk(VT, LIT, 0, 5'b10000));
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL search_to_align: got locked=%0b expected 0", locked);
    end
    run_to_vlead(1, mk(VT, LIT, 1, 5'b10000));
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    while (vy != 10 && n < HT * VT) begin drive_tick(); n++; end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({locked, frame_done, err, h_total, h_sync_w, h_active, v_total, v_sync_w, v_active, lit_count} !== 93'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got locked=%0b err=%b h_total=%0d lit=%0d expected all 0",
               locked, err, h_total, lit_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_to_vlead(0, mk(VT, LIT, 0, 0));
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_early: got locked=%0b expected 0", locked);
    end
    run_to_vlead(1, mk(VT, LIT, 1, 0));
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_glyphs();
    test_short_line();
    test_err_clr();
    test_timeout();
    test_reset_midframe();
    run_ticks(4);
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
